// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the writeback arbiter.
// Configuration macro: WB_ARB_RR_EN (see wb_arbiter.sv).
package wb_arb_pkg;

  localparam int unsigned NUM_REQ_DEF  = 4;   // 0=ALU, 1=MUL, 2=DIV, 3=LOAD
  localparam int unsigned XLEN_DEF     = 64;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned RD_W         = 5;

  typedef logic [RD_W-1:0] rd_idx_t;

  typedef struct packed {
    logic                valid;
    rd_idx_t             rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  // Width of a requester index; never zero so a single requester still has a legal vector.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority picker: one-hot grant to the first set request at or after ptr.
// With ptr held at zero this degenerates to lowest-index-wins fixed priority.
module rr_picker
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  // Scan positions ptr, ptr+1, ... modulo NUM_REQ; the first requesting one wins.
  always_comb begin
    logic        found;
    int unsigned pos;
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (pos == j) && req[j]) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one requester per cycle and drives the register-file write
// port and wakeup broadcast from a single registered output stage.
// Configuration macro: WB_ARB_RR_EN -- defined selects round-robin priority with a
// rotating pointer; undefined selects fixed lowest-index-first priority.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          FLUSH,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ-1:0][RD_W-1:0]  REQ_RD,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  REQ_DATA,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REGS-1:0]           RF_EN,
  output logic [XLEN-1:0]               RF_DIN,
  output logic                          WB_VALID,
  output logic [RD_W-1:0]               WB_RD
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0]  req_live;
  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    ptr;
  logic                accept;
  logic                wr_ok;
  rd_idx_t             sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic [NUM_REGS-1:0] en_d;

  // Reset and flush withhold every grant in the current cycle.
  assign req_live = (RST || FLUSH) ? '0 : REQ_VALID;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req (req_live),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign REQ_READY = gnt;
  assign accept    = |gnt;

  // The grant is one-hot, so OR-ing the masked payloads selects the winner.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = sel_rd | REQ_RD[i];
        sel_data = sel_data | REQ_DATA[i];
      end
    end
  end

`ifdef WB_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_idx;

  // Binary index of the winner, used to advance the pointer past it.
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_idx = PTR_W'(i);
    end
  end

  // Winner becomes lowest priority next cycle; idle or flushed cycles leave ptr alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // A grant to r0 (or to an index beyond the file) is consumed with no visible write.
  assign wr_ok = accept && (sel_rd != '0) && (32'(sel_rd) < NUM_REGS);

  // Decode the destination index into the per-register enable vector.
  always_comb begin
    en_d = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      en_d[r] = wr_ok && (32'(sel_rd) == r);
    end
  end

  // Output stage holds each write for exactly one cycle; reset clears rather than re-issues.
  always_ff @(posedge CLK) begin
    if (RST || !wr_ok) begin
      RF_EN    <= '0;
      RF_DIN   <= '0;
      WB_VALID <= 1'b0;
      WB_RD    <= '0;
    end else begin
      RF_EN    <= en_d;
      RF_DIN   <= sel_data;
      WB_VALID <= 1'b1;
      WB_RD    <= sel_rd;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand-written grant-order and reset
// sequences, then randomized traffic against a queue-free priority model.
// Honours WB_ARB_RR_EN for the expected priority order.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [3:0]       valid;
  logic [3:0][4:0]  rd;
  logic [3:0][63:0] data;
  logic [3:0]       ready;
  logic [31:0]      rf_en;
  logic [63:0]      rf_din;
  logic             wb_valid;
  logic [4:0]       wb_rd;

  int checks = 0;
  int passed = 0;
  int m_ptr  = 0;

  logic        have_last = 1'b0;
  logic [31:0] last_en   = '0;
  logic        last_wv   = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .NUM_REQ  (4),
    .XLEN     (64),
    .NUM_REGS (32)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .FLUSH     (flush),
    .REQ_VALID (valid),
    .REQ_RD    (rd),
    .REQ_DATA  (data),
    .REQ_READY (ready),
    .RF_EN     (rf_en),
    .RF_DIN    (rf_din),
    .WB_VALID  (wb_valid),
    .WB_RD     (wb_rd)
  );

  typedef struct {
    logic        r;
    logic        f;
    logic [3:0]  v;
    logic [19:0] rdp;    // {rd3, rd2, rd1, rd0}
    logic [63:0] base;   // requester i presents base + i
    logic [3:0]  e_ready;
    logic [31:0] e_en;
    logic        e_wv;
    logic [4:0]  e_rd;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic f, input logic [3:0] v,
                               input logic [19:0] rdp, input logic [63:0] base,
                               input logic [3:0] er, input logic [31:0] ee,
                               input logic ew, input logic [4:0] erd);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.rdp = rdp; t.base = base;
    t.e_ready = er; t.e_en = ee; t.e_wv = ew; t.e_rd = erd;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  // Inputs already driven; check the combinational grant, cross the edge, check outputs.
  task automatic cycle(input string tag, input logic [3:0] e_ready, input logic [31:0] e_en,
                       input logic [63:0] e_din, input logic e_wv, input logic [4:0] e_rd);
    #1;
    check({tag, ".ready"}, 64'(ready), 64'(e_ready));
    if (have_last) begin
      check({tag, ".held_en"}, 64'(rf_en), 64'(last_en));
      check({tag, ".held_wv"}, 64'(wb_valid), 64'(last_wv));
    end
    @(posedge clk);
    #1;
    check({tag, ".rf_en"}, 64'(rf_en), 64'(e_en));
    check({tag, ".rf_din"}, rf_din, e_din);
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'(e_wv));
    check({tag, ".wb_rd"}, 64'(wb_rd), 64'(e_rd));
    last_en   = e_en;
    last_wv   = e_wv;
    have_last = 1'b1;
  endtask

  task automatic drive(input logic r, input logic f, input logic [3:0] v,
                       input logic [19:0] rdp, input logic [63:0] base);
    rst   = r;
    flush = f;
    valid = v;
    rd    = rdp;
    for (int i = 0; i < 4; i++) data[i] = base + 64'(i);
  endtask

  // Reference priority: scan from the pointer (round-robin) or from 0 (fixed).
  function automatic int pick(input logic r, input logic f, input logic [3:0] v);
    if (r || f) return -1;
    for (int k = 0; k < 4; k++) begin
`ifdef WB_ARB_RR_EN
      int idx = (m_ptr + k) % 4;
`else
      int idx = k;
`endif
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input string tag, output int w);
    logic [3:0]  er;
    logic [31:0] ee;
    logic [63:0] ed;
    logic        ew;
    logic [4:0]  erd;
    w   = pick(rst, flush, valid);
    er  = (w >= 0) ? 4'(1 << w) : 4'b0;
    ee  = '0; ed = '0; ew = 1'b0; erd = '0;
    if (w >= 0 && rd[w] != 5'd0) begin
      ee  = 32'd1 << rd[w];
      ed  = data[w];
      ew  = 1'b1;
      erd = rd[w];
    end
    cycle(tag, er, ee, ed, ew, erd);
    if (rst) m_ptr = 0;
    else if (w >= 0) m_ptr = (w + 1) % 4;
  endtask

  vec_t tbl[11];
  logic [3:0]  seq_ready[5];
  logic [31:0] seq_en[5];

  initial begin
    int w;
    logic [63:0] e_din;

    // Rows run back to back from reset; rows 7/8 share a base so req1 holds its payload.
    tbl[0]  = mkv(1, 0, 4'b1111, {5'd3, 5'd3, 5'd3, 5'd3}, 64'h0,
                  4'b0000, 32'h0, 0, 5'd0);
    tbl[1]  = mkv(0, 0, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, 64'hDEAD_BEEF_0000_0000,
                  4'b0010, 32'h0000_0020, 1, 5'd5);
    tbl[2]  = mkv(0, 0, 4'b0100, {5'd0, 5'd0, 5'd0, 5'd0}, 64'h1111_0000_0000_0000,
                  4'b0100, 32'h0, 0, 5'd0);
    tbl[3]  = mkv(0, 0, 4'b0000, {5'd8, 5'd8, 5'd8, 5'd8}, 64'h2222_0000_0000_0000,
                  4'b0000, 32'h0, 0, 5'd0);
    tbl[4]  = mkv(0, 0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, 64'h3333_0000_0000_0000,
                  4'b0001, 32'h0000_0080, 1, 5'd7);
    tbl[5]  = mkv(0, 1, 4'b1111, {5'd9, 5'd9, 5'd9, 5'd9}, 64'h4444_0000_0000_0000,
                  4'b0000, 32'h0, 0, 5'd0);
    tbl[6]  = mkv(0, 0, 4'b1000, {5'd12, 5'd0, 5'd0, 5'd0}, 64'h5555_0000_0000_0000,
                  4'b1000, 32'h0000_1000, 1, 5'd12);
    tbl[7]  = mkv(0, 0, 4'b0011, {5'd0, 5'd0, 5'd9, 5'd9}, 64'h6666_0000_0000_0000,
                  4'b0001, 32'h0000_0200, 1, 5'd9);
    tbl[8]  = mkv(0, 0, 4'b0010, {5'd0, 5'd0, 5'd9, 5'd9}, 64'h6666_0000_0000_0000,
                  4'b0010, 32'h0000_0200, 1, 5'd9);
    tbl[9]  = mkv(1, 0, 4'b1111, {5'd4, 5'd4, 5'd4, 5'd4}, 64'h7777_0000_0000_0000,
                  4'b0000, 32'h0, 0, 5'd0);
    tbl[10] = mkv(0, 0, 4'b1000, {5'd31, 5'd0, 5'd0, 5'd0}, 64'h8888_0000_0000_0000,
                  4'b1000, 32'h8000_0000, 1, 5'd31);

    drive(1, 0, 4'b0000, 20'h0, 64'h0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 11; n++) begin
      drive(tbl[n].r, tbl[n].f, tbl[n].v, tbl[n].rdp, tbl[n].base);
      e_din = '0;
      for (int i = 0; i < 4; i++) begin
        if (tbl[n].e_ready[i] && tbl[n].e_wv) e_din = tbl[n].base + 64'(i);
      end
      cycle($sformatf("vec%0d", n), tbl[n].e_ready, tbl[n].e_en, e_din, tbl[n].e_wv,
            tbl[n].e_rd);
    end

    // Grant order with all four requesting continuously from a fresh reset.
`ifdef WB_ARB_RR_EN
    seq_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_en    = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h2};
`else
    seq_ready = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    seq_en    = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h2};
`endif
    drive(1, 0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 64'hA000_0000_0000_0000);
    cycle("order_rst", 4'b0000, 32'h0, 64'h0, 0, 5'd0);
    for (int c = 0; c < 5; c++) begin
      int g = 0;
      drive(0, 0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 64'hA000_0000_0000_0000);
      for (int i = 0; i < 4; i++) if (seq_ready[c][i]) g = i;
      cycle($sformatf("order%0d", c), seq_ready[c], seq_en[c],
            64'hA000_0000_0000_0000 + 64'(g), 1, 5'(g + 1));
    end

    // Reset right after an acceptance: write dropped, pointer back to 0, req3 served at once.
    drive(0, 0, 4'b0010, {5'd0, 5'd0, 5'd3, 5'd0}, 64'hB000_0000_0000_0000);
    cycle("rs_acc", 4'b0010, 32'h8, 64'hB000_0000_0000_0001, 1, 5'd3);
    drive(1, 0, 4'b0110, {5'd0, 5'd6, 5'd4, 5'd0}, 64'hB100_0000_0000_0000);
    cycle("rs_mid", 4'b0000, 32'h0, 64'h0, 0, 5'd0);
    drive(0, 0, 4'b1000, {5'd17, 5'd0, 5'd0, 5'd0}, 64'hB200_0000_0000_0000);
    cycle("rs_req3", 4'b1000, 32'h0002_0000, 64'hB200_0000_0000_0003, 1, 5'd17);
    drive(0, 0, 4'b0010, {5'd0, 5'd0, 5'd3, 5'd0}, 64'hB300_0000_0000_0000);
    cycle("rs_acc2", 4'b0010, 32'h8, 64'hB300_0000_0000_0001, 1, 5'd3);
    drive(1, 0, 4'b0110, {5'd0, 5'd6, 5'd4, 5'd0}, 64'hB400_0000_0000_0000);
    cycle("rs_mid2", 4'b0000, 32'h0, 64'h0, 0, 5'd0);
    drive(0, 0, 4'b0110, {5'd0, 5'd6, 5'd4, 5'd0}, 64'hB400_0000_0000_0000);
    cycle("rs_ptr0", 4'b0010, 32'h10, 64'hB400_0000_0000_0001, 1, 5'd4);

    // Randomized traffic; a requester keeps its payload until granted or reset.
    drive(1, 0, 4'b0000, 20'h0, 64'h0);
    model_step("rnd_rst", w);
    for (int i = 0; i < 4; i++) begin
      valid[i] = ($urandom % 4) != 0;
      rd[i]    = 5'($urandom);
      data[i]  = {$urandom, $urandom};
    end
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom % 50) == 0;
      flush = ($urandom % 8) == 0;
      model_step($sformatf("rnd%0d", c), w);
      for (int i = 0; i < 4; i++) begin
        if (rst || !valid[i] || (w == i)) begin
          valid[i] = ($urandom % 4) != 0;
          rd[i]    = 5'($urandom);
          data[i]  = {$urandom, $urandom};
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
